mean_unit: RTL and testbench
============================

Name: mean_unit

Overview:
- Streaming fixed-point averager.
- Accumulates a block of `data_len` unsigned 32-bit samples framed by `start_data`, then divides the sum by `data_len` with a sequential divider.
- Holds the result as an unsigned fixed-point mean with `frac_bits` fractional bits until the next block completes.
- Used as a statistics stage in the image/data pipeline, ahead of variance/normalisation logic.

Parameters:
- frac_bits, 8: number of fractional bits in `mean`. Legal range 0..16.
- DATA_W, 32: width of `data_in` and `mean`.
- LEN_W, 32: width of `data_len`.
- ACC_W, 64: accumulator width. Must be ≥ DATA_W + LEN_W so the accumulator never overflows.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- data_len  input  LEN_W  samples per block; sampled on the cycle `start_data` is high.
- data_in  input  DATA_W  unsigned sample; accepted when `valid` = 1.
- valid  input  1  sample qualifier.
- start_data  input  1  block-start strobe.
- mean  output  DATA_W  unsigned Q(DATA_W−frac_bits).frac_bits mean of the last completed block.

Behaviour:
- Reset (reset = 0, asynchronous): `mean` = 0, accumulator = 0, sample count = 0, latched length = 0, FSM = IDLE, divider idle.
- Accumulator FSM states: IDLE, ACCUM.
- `start_data` = 1 in any state:
  - Clears the accumulator and count, latches `data_len`, goes to ACCUM.
  - If `valid` is also 1 in that cycle, that sample is the block's first sample (accumulator = `data_in`, count = 1).
  - A block in progress is discarded with no effect on `mean`.
- In ACCUM, each cycle with `valid` = 1 and `start_data` = 0: accumulator += `data_in`, count += 1.
- When count reaches the latched length:
  - The sum and length are handed to the divider on the next edge.
  - FSM returns to IDLE.
  - Further `valid` samples are ignored until the next `start_data`.
- Latched length = 0: block is ignored, FSM stays IDLE, `mean` unchanged.
- `valid` in IDLE without `start_data`: ignored.
- Divider (restoring, one quotient bit per cycle):
  - Dividend = sum << frac_bits. Divisor = latched length.
  - Quotient is DATA_W bits, truncated (floor).
  - If sum << frac_bits ≥ length << DATA_W, the result saturates to all ones.
- Latency, counting the edge that accepts the final sample as edge 0:
  - Edge 1: divider loads.
  - Edges 2..33: 32 iterations.
  - Edge 34: `mean` is updated.
- `mean` holds its value between updates; it changes only at divider completion or reset.
- A new block may be accumulated while the divider runs; the divider owns its latched operands.
- If a second block completes while the divider is still busy:
  - Its operands are queued in a one-deep holding register.
  - Division starts the cycle after the current one finishes.
  - A third completion overwrites the queued entry.
- `start_data` does not abort a division already in progress.
- Reset mid-operation: all state is cleared, including a pending or in-flight division.

Optional Feature:
- Macro MEAN_UNIT_DONE_EN.
- When defined: adds output port `mean_valid` (1 bit). It pulses high for exactly one cycle, coincident with each `mean` update edge, and is 0 in reset.
- When undefined: the port and its logic are absent; `mean` behaviour is identical.

Decomposition:
- Package `mean_unit_pkg`:
  - DIV_ITER = DATA_W.
  - Typedef of the FSM state enum (IDLE, ACCUM).
  - Typedefs for the accumulator and length types.
- One sub-module, `seq_divider`, with ports: start, dividend, divisor, busy, done, quotient, plus saturation detect.
- `mean_unit` holds the accumulator FSM, the holding register and the output register.

Test Plan:
- Reset asserted then released → `mean` = 0. No `start_data` and `valid` = 1 with `data_in` = 7 → `mean` stays 0.
- data_len = 25; `start_data` with the first of 25 samples of 3 → `mean` = 0x300 (768) on edge 34 after the last sample.
- Immediately afterwards, `start_data`, then 25 samples of 2 (`start_data` one cycle before the first `valid`) → `mean` = 0x200.
- data_len = 3; samples 1, 2, 2 → `mean` = floor(5·256/3) = 426 (0x1AA).
- Aborted and empty blocks:
  - Only one sample of 10 (data_len = 25) before the next `start_data` → `mean` unchanged.
  - `start_data` with data_len = 0 → `mean` unchanged.
- Overflow and reset checks:
  - data_len = 1, sample 0xFFFFFFFF → saturates to 0xFFFFFFFF.
  - Reset during the divider run → `mean` = 0 and no later update.

Source files
------------

// File: rtl/mean_unit_pkg.sv
// mean_unit_pkg: shared constants and types for the streaming mean unit.
//   DIV_ITER  - quotient bits produced by the sequential divider (one per cycle)
//   state_t   - accumulator FSM state
//   acc_t     - default-width accumulator type
//   len_t     - default-width block length type
package mean_unit_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 32;
    localparam int ACC_W_DEF  = 64;
    localparam int DIV_ITER   = DATA_W_DEF;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    typedef logic [ACC_W_DEF-1:0] acc_t;
    typedef logic [LEN_W_DEF-1:0] len_t;

endpackage

// File: rtl/mean_unit_seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per clock.
//   clk, reset (async, active-low)
//   start     - load operands (ignored while busy)
//   dividend  - DVD_W-bit dividend
//   divisor   - DVS_W-bit divisor
//   busy      - high from the load edge until the result edge
//   done      - high in the cycle before the result edge; quotient valid then
//   quotient  - Q_W-bit floor quotient, all ones when it would not fit
//   saturated - quotient overflow detected at load
// Timing: load edge, then Q_W iteration edges, then one edge with done high.
module seq_divider
    import mean_unit_pkg::*;
#(
    parameter int DVD_W = 72,
    parameter int DVS_W = 32,
    parameter int Q_W   = DIV_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [Q_W-1:0]   quotient,
    output logic             saturated
);

    localparam int CNT_W = $clog2(Q_W + 1);

    logic [CNT_W-1:0] cnt;
    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] dvs;
    logic [Q_W-1:0]   shreg;
    logic [DVS_W:0]   trial;
    logic             q_bit;
    logic [DVD_W:0]   limit;
    logic             sat_detect;

    // Overflow when dividend >= divisor * 2^Q_W; a zero divisor also lands here.
    always_comb begin
        limit      = (DVD_W + 1)'(divisor) << Q_W;
        sat_detect = ({1'b0, dividend} >= limit);
    end

    // Partial remainder stays below the divisor, so one extra bit suffices
    // for the shifted trial value.
    always_comb begin
        trial = {rem, shreg[Q_W-1]};
        q_bit = (trial >= {1'b0, dvs});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            cnt       <= '0;
            rem       <= '0;
            dvs       <= '0;
            shreg     <= '0;
            saturated <= 1'b0;
        end else if (start && !busy) begin
            busy      <= 1'b1;
            cnt       <= CNT_W'(Q_W);
            rem       <= DVS_W'(dividend >> Q_W);
            shreg     <= dividend[Q_W-1:0];
            dvs       <= divisor;
            saturated <= sat_detect;
        end else if (busy) begin
            if (cnt != '0) begin
                cnt   <= cnt - CNT_W'(1);
                rem   <= q_bit ? DVS_W'(trial - {1'b0, dvs}) : DVS_W'(trial);
                // Dividend bits shift out the top while quotient bits enter below.
                shreg <= {shreg[Q_W-2:0], q_bit};
            end else begin
                busy <= 1'b0;
            end
        end
    end

    assign done     = busy && (cnt == '0);
    assign quotient = saturated ? '1 : shreg;

endmodule

// File: rtl/mean_unit.sv
// mean_unit: streaming fixed-point averager.
// Accumulates data_len unsigned samples framed by start_data, divides the sum
// (scaled by 2^frac_bits) by the length, and holds the mean until the next
// completed block.
//   clk        - rising-edge clock
//   reset      - asynchronous, active-low reset
//   data_len   - samples per block, sampled with start_data
//   data_in    - unsigned sample, accepted when valid
//   valid      - sample qualifier
//   start_data - block-start strobe
//   mean       - Q(DATA_W-frac_bits).frac_bits mean of the last block
//   mean_valid - one-cycle pulse on each mean update (only with MEAN_UNIT_DONE_EN)
// Optional feature macro: MEAN_UNIT_DONE_EN.
module mean_unit
    import mean_unit_pkg::*;
#(
    parameter int frac_bits = 8,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int LEN_W     = LEN_W_DEF,
    parameter int ACC_W     = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LEN_W-1:0]  data_len,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    input  logic              start_data,
    output logic [DATA_W-1:0] mean
`ifdef MEAN_UNIT_DONE_EN
    ,
    output logic              mean_valid
`endif
);

    localparam int DVD_W = ACC_W + frac_bits;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [LEN_W-1:0]   count;
    logic [LEN_W-1:0]   len_q;

    logic               pend_valid;
    logic [ACC_W-1:0]   pend_sum;
    logic [LEN_W-1:0]   pend_len;

    logic               handoff;
    logic               div_start;
    logic [DVD_W-1:0]   div_dividend;
    logic [LEN_W-1:0]   div_divisor;
    logic               div_busy;
    logic               div_done;
    logic [DATA_W-1:0]  div_quotient;
    logic               div_sat;

    // A full block is handed off the cycle after its final sample lands.
    // The queued block is older, so it goes to the divider first.
    always_comb begin
        handoff      = (state == ACCUM) && (count == len_q);
        div_start    = !div_busy && (pend_valid || handoff);
        div_dividend = pend_valid ? (DVD_W'(pend_sum) << frac_bits)
                                  : (DVD_W'(acc) << frac_bits);
        div_divisor  = pend_valid ? pend_len : len_q;
    end

    // Accumulator FSM; a zero-length block never leaves IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
            len_q <= '0;
        end else if (start_data) begin
            acc   <= valid ? ACC_W'(data_in) : '0;
            count <= valid ? LEN_W'(1) : '0;
            len_q <= data_len;
            state <= (data_len == '0) ? IDLE : ACCUM;
        end else if (state == ACCUM) begin
            if (count == len_q) begin
                state <= IDLE;
            end else if (valid) begin
                acc   <= acc + ACC_W'(data_in);
                count <= count + LEN_W'(1);
            end
        end
    end

    // One-deep holding register; a newer completion replaces a queued one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_valid <= 1'b0;
            pend_sum   <= '0;
            pend_len   <= '0;
        end else if (handoff && (div_busy || pend_valid)) begin
            pend_valid <= 1'b1;
            pend_sum   <= acc;
            pend_len   <= len_q;
        end else if (div_start && pend_valid) begin
            pend_valid <= 1'b0;
        end
    end

    seq_divider #(
        .DVD_W (DVD_W),
        .DVS_W (LEN_W),
        .Q_W   (DATA_W)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quotient),
        .saturated (div_sat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mean <= '0;
        end else if (div_done) begin
            mean <= div_quotient;
        end
    end

`ifdef MEAN_UNIT_DONE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mean_valid <= 1'b0;
        end else begin
            mean_valid <= div_done;
        end
    end
`endif

endmodule

// File: tb/tb_mean_unit.sv
module tb_mean_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_len;
    logic [31:0] data_in;
    logic        valid;
    logic        start_data;
    logic [31:0] mean;
`ifdef MEAN_UNIT_DONE_EN
    logic        mean_valid;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mean_unit dut (
        .clk        (clk),
        .reset      (reset),
        .data_len   (data_len),
        .data_in    (data_in),
        .valid      (valid),
        .start_data (start_data),
        .mean       (mean)
`ifdef MEAN_UNIT_DONE_EN
        ,
        .mean_valid (mean_valid)
`endif
    );

    always #5 clk = ~clk;

    // Advance n rising edges; return 1 time unit after the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset      = 1'b0;
        data_len   = '0;
        data_in    = '0;
        valid      = 1'b0;
        start_data = 1'b0;

        // Reset state
        tick(3);
        check("reset_mean", mean, 32'h0);
        reset = 1'b1;
        tick(2);
        check("post_reset_mean", mean, 32'h0);
`ifdef MEAN_UNIT_DONE_EN
        check("post_reset_mean_valid", {31'b0, mean_valid}, 32'h0);
`endif

        // valid without start_data in IDLE is ignored
        valid   = 1'b1;
        data_in = 32'd7;
        tick(5);
        valid = 1'b0;
        tick(40);
        check("idle_valid_ignored", mean, 32'h0);

        // Block A: 25 samples of 3, start_data with the first sample
        data_len   = 32'd25;
        start_data = 1'b1;
        valid      = 1'b1;
        data_in    = 32'd3;
        tick(1);
        start_data = 1'b0;
        tick(24);                      // last sample accepted: edge 0
        // Block B: start_data alone, then 25 samples of 2
        valid      = 1'b0;
        start_data = 1'b1;
        tick(1);                       // edge 1
        start_data = 1'b0;
        valid      = 1'b1;
        data_in    = 32'd2;
        tick(25);                      // edges 2..26, B's last sample at 26
        valid = 1'b0;
        tick(7);                       // edge 33
        check("blockA_before_latency", mean, 32'h0);
`ifdef MEAN_UNIT_DONE_EN
        check("blockA_valid_low", {31'b0, mean_valid}, 32'h0);
`endif
        tick(1);                       // edge 34
        check("blockA_mean", mean, 32'h300);
`ifdef MEAN_UNIT_DONE_EN
        check("blockA_valid_pulse", {31'b0, mean_valid}, 32'h1);
        tick(1);
        check("blockA_valid_one_cycle", {31'b0, mean_valid}, 32'h0);
        tick(32);                      // edge 67
`else
        tick(33);                      // edge 67
`endif
        // B was queued; divider restarts at edge 35, finishes at edge 68
        check("blockB_before_latency", mean, 32'h300);
        tick(1);
        check("blockB_mean", mean, 32'h200);

        // Block C: length 3, samples 1, 2, 2 -> floor(1280/3) = 426
        data_len   = 32'd3;
        start_data = 1'b1;
        valid      = 1'b1;
        data_in    = 32'd1;
        tick(1);
        start_data = 1'b0;
        data_in    = 32'd2;
        tick(2);
        valid = 1'b0;
        tick(33);
        check("blockC_before_latency", mean, 32'h200);
        tick(1);
        check("blockC_mean", mean, 32'h1AA);

        // Aborted block (one sample of 10), then an empty block, then stray valids
        data_len   = 32'd25;
        start_data = 1'b1;
        valid      = 1'b1;
        data_in    = 32'd10;
        tick(1);
        valid    = 1'b0;
        data_len = 32'd0;
        tick(1);
        start_data = 1'b0;
        valid      = 1'b1;
        data_in    = 32'd5;
        tick(4);
        valid = 1'b0;
        tick(60);
        check("abort_and_empty_unchanged", mean, 32'h1AA);

        // Saturation: length 1, sample 0xFFFFFFFF
        data_len   = 32'd1;
        start_data = 1'b1;
        valid      = 1'b1;
        data_in    = 32'hFFFF_FFFF;
        tick(1);
        start_data = 1'b0;
        valid      = 1'b0;
        tick(33);
        check("sat_before_latency", mean, 32'h1AA);
        tick(1);
        check("sat_mean", mean, 32'hFFFF_FFFF);

        // Largest non-saturating single sample: 0x00FFFFFF << 8
        start_data = 1'b1;
        valid      = 1'b1;
        data_in    = 32'h00FF_FFFF;
        tick(1);
        start_data = 1'b0;
        valid      = 1'b0;
        tick(34);
        check("nonsat_edge_mean", mean, 32'hFFFF_FF00);

        // Reset during a divider run clears mean and cancels the division
        data_len   = 32'd2;
        start_data = 1'b1;
        valid      = 1'b1;
        data_in    = 32'd100;
        tick(1);
        start_data = 1'b0;
        data_in    = 32'd300;
        tick(1);
        valid = 1'b0;
        tick(10);
        reset = 1'b0;
        #1;
        check("async_reset_mean", mean, 32'h0);
        tick(2);
        reset = 1'b1;
        tick(60);
        check("no_update_after_reset", mean, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
